// File: rtl/sum_accumulator.sv
// Running a+b accumulator behind a valid/ready operand handshake, with a registered result channel.
// Optional macro SUM_ACCUMULATOR_SATURATE_EN clamps the total on overflow instead of wrapping.
`timescale 1ns/1ps
module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              clear_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;

  // Internal running state; cleared independently of the held result.
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;

  logic [ACC_W-1:0]  sum_r;
  logic [CNT_W-1:0]  count_r;
  logic              ovf_out_r;

  logic [ACC_W-1:0]  base_acc_s;
  logic [CNT_W-1:0]  base_cnt_s;
  logic              base_ovf_s;
  logic [ACC_W:0]    sum_ext_s;
  logic [ACC_W-1:0]  acc_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              ovf_nxt_s;

  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] acc,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return {1'b0, acc}
         + {{(ACC_W+1-DATA_W){1'b0}}, a}
         + {{(ACC_W+1-DATA_W){1'b0}}, b};
  endfunction

  // Handshake outputs derived from the current state.
  always_comb begin
    out_valid = (state_r == FULL);
    in_ready  = (state_r == EMPTY) || out_ready;
    accept_s  = in_valid && in_ready;
  end

  // Result-channel state transitions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_nxt_s = FULL;
        else          state_nxt_s = EMPTY;
      end
      FULL: begin
        if (accept_s)       state_nxt_s = FULL;
        else if (out_ready) state_nxt_s = EMPTY;
        else                state_nxt_s = FULL;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= EMPTY;
    else        state_r <= state_nxt_s;
  end

  // Clear is applied before the incoming pair, so a same-cycle add starts from zero.
  always_comb begin
    if (clear_i) begin
      base_acc_s = '0;
      base_cnt_s = '0;
      base_ovf_s = 1'b0;
    end else begin
      base_acc_s = acc_r;
      base_cnt_s = cnt_r;
      base_ovf_s = ovf_r;
    end
    sum_ext_s = add_ext(base_acc_s, a_i, b_i);
    cnt_nxt_s = base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
    if (sum_ext_s[ACC_W]) begin
      ovf_nxt_s = 1'b1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      acc_nxt_s = {ACC_W{1'b1}};
`else
      acc_nxt_s = sum_ext_s[ACC_W-1:0];
`endif
    end else begin
      ovf_nxt_s = base_ovf_s;
      acc_nxt_s = sum_ext_s[ACC_W-1:0];
    end
  end

  // Accumulator state and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      sum_r     <= '0;
      count_r   <= '0;
      ovf_out_r <= 1'b0;
    end else if (accept_s) begin
      acc_r     <= acc_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ovf_r     <= ovf_nxt_s;
      sum_r     <= acc_nxt_s;
      count_r   <= cnt_nxt_s;
      ovf_out_r <= ovf_nxt_s;
    end else if (clear_i) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
    end else begin
      acc_r     <= acc_r;
      cnt_r     <= cnt_r;
      ovf_r     <= ovf_r;
    end
  end

  assign sum_o   = sum_r;
  assign count_o = count_r;
  assign ovf_o   = ovf_out_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model of the running total.
`timescale 1ns/1ps
module tb_sum_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_i = 8'd0;
  logic [7:0]  b_i = 8'd0;
  logic        clear_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum_o;
  logic [7:0]  count_o;
  logic        ovf_o;

  int n_checks = 0;
  int n_pass = 0;

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .clear_i(clear_i), .out_valid(out_valid),
    .out_ready(out_ready), .sum_o(sum_o), .count_o(count_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: running total, pair count, sticky overflow, and the result last presented.
  int m_acc, m_cnt, m_ovf;
  int e_valid, e_sum, e_cnt, e_ovf;
  int n_acc, n_cnt, n_ovf, n_raw;
  bit m_accept;

  always_comb begin
    m_accept = in_valid && (e_valid == 0 || out_ready);
    n_acc = clear_i ? 0 : m_acc;
    n_cnt = clear_i ? 0 : m_cnt;
    n_ovf = clear_i ? 0 : m_ovf;
    n_raw = n_acc + int'(a_i) + int'(b_i);
    n_cnt = (n_cnt + 1) % 256;
    if (n_raw > 65535) begin
      n_ovf = 1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      n_acc = 65535;
`else
      n_acc = n_raw - 65536;
`endif
    end else begin
      n_acc = n_raw;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= 0; m_cnt <= 0; m_ovf <= 0;
      e_valid <= 0; e_sum <= 0; e_cnt <= 0; e_ovf <= 0;
    end else if (m_accept) begin
      m_acc <= n_acc; m_cnt <= n_cnt; m_ovf <= n_ovf;
      e_valid <= 1; e_sum <= n_acc; e_cnt <= n_cnt; e_ovf <= n_ovf;
    end else begin
      if (clear_i) begin
        m_acc <= 0; m_cnt <= 0; m_ovf <= 0;
      end
      if (out_ready) e_valid <= 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), e_valid);
      chk("in_ready", int'(in_ready), (e_valid == 0 || out_ready) ? 1 : 0);
      if (e_valid != 0) begin
        chk("sum_o", int'(sum_o), e_sum);
        chk("count_o", int'(count_o), e_cnt);
        chk("ovf_o", int'(ovf_o), e_ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int a, input int b, input bit clr);
    in_valid = 1'b1; a_i = 8'(a); b_i = 8'(b); clear_i = clr;
    tick();
    in_valid = 1'b0; clear_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    out_ready = 1'b1;
    tick();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset sum_o", int'(sum_o), 0);
    chk("reset count_o", int'(count_o), 0);
    chk("reset ovf_o", int'(ovf_o), 0);
    rst_n = 1'b1;

    // Back-to-back pairs with the consumer always ready.
    in_valid = 1'b1; a_i = 8'd3; b_i = 8'd4;
    tick();
    chk("t1 sum0", int'(sum_o), 7);
    chk("t1 cnt0", int'(count_o), 1);
    chk("t1 ready0", int'(in_ready), 1);
    a_i = 8'd10; b_i = 8'd20;
    tick();
    chk("t1 sum1", int'(sum_o), 37);
    chk("t1 cnt1", int'(count_o), 2);
    chk("t1 valid1", int'(out_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("t1 valid drop", int'(out_valid), 0);

    // Clear together with a pair.
    send(5, 6, 1'b1);
    chk("t3 sum", int'(sum_o), 11);
    chk("t3 cnt", int'(count_o), 1);
    chk("t3 ovf", int'(ovf_o), 0);

    // Clear alone: no result, next pair starts fresh.
    send(13, 13, 1'b0);
    chk("t6 pre sum", int'(sum_o), 37);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("t6 no pulse", int'(out_valid), 0);
    chk("t6 held sum", int'(sum_o), 37);
    send(1, 2, 1'b0);
    chk("t6 sum", int'(sum_o), 3);
    chk("t6 cnt", int'(count_o), 1);

    // Backpressure: result held, second pair waits.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; a_i = 8'd1; b_i = 8'd1;
    tick();
    a_i = 8'd2; b_i = 8'd2;
    for (int i = 0; i < 3; i++) begin
      chk("t2 hold sum", int'(sum_o), 2);
      chk("t2 hold cnt", int'(count_o), 1);
      chk("t2 hold valid", int'(out_valid), 1);
      chk("t2 hold ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t2 ready comb", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("t2 sum", int'(sum_o), 6);
    chk("t2 cnt", int'(count_o), 2);
    tick();

    // Build up to 0xFFF0, then overflow.
    send(255, 255, 1'b1);
    for (int i = 0; i < 127; i++) send(255, 255, 1'b0);
    send(240, 0, 1'b0);
    chk("t4 pre", int'(sum_o), 16'hFFF0);
    chk("t4 pre ovf", int'(ovf_o), 0);
    send(16'h10, 16'h05, 1'b0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    chk("t4 sat", int'(sum_o), 16'hFFFF);
`else
    chk("t4 wrap", int'(sum_o), 16'h0005);
`endif
    chk("t4 ovf", int'(ovf_o), 1);
    send(1, 1, 1'b0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    chk("t4 sat hold", int'(sum_o), 16'hFFFF);
`else
    chk("t4 wrap next", int'(sum_o), 16'h0007);
`endif
    chk("t4 ovf sticky", int'(ovf_o), 1);

    // Asynchronous reset while a result is stalled.
    out_ready = 1'b0;
    send(9, 9, 1'b0);
    chk("t5 pre valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5 valid", int'(out_valid), 0);
    chk("t5 sum", int'(sum_o), 0);
    chk("t5 cnt", int'(count_o), 0);
    chk("t5 ovf", int'(ovf_o), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2, 3, 1'b0);
    chk("t5 first sum", int'(sum_o), 5);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear_i   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) begin
        a_i = 8'($urandom_range(200, 255));
        b_i = 8'($urandom_range(200, 255));
      end else begin
        a_i = 8'($urandom);
        b_i = 8'($urandom);
      end
      tick();
    end
    in_valid = 1'b0; clear_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
